// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between instruction fetch
// and load/store; one access in flight, registered read data with a one-cycle ack.
module memory_arbiter #(
  parameter int XLEN         = 32,
  parameter int LS_SEL_WIDTH = 2
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Fetch_Req,
  input  logic [XLEN-1:0]       i_Fetch_Addr,
  output logic                  o_Fetch_Ack,
  output logic [XLEN-1:0]       o_Fetch_Data,
  input  logic                  i_Ls_Req,
  input  logic                  i_Ls_Write_Enable,
  input  logic [LS_SEL_WIDTH:0] i_Ls_Type,
  input  logic [XLEN-1:0]       i_Ls_Addr,
  input  logic [XLEN-1:0]       i_Ls_Data,
  output logic                  o_Ls_Ack,
  output logic [XLEN-1:0]       o_Ls_Data,
  output logic                  o_Mem_Write_Enable,
  output logic [LS_SEL_WIDTH:0] o_Mem_Load_Store_Type,
  output logic [XLEN-1:0]       o_Mem_Addr,
  output logic [XLEN-1:0]       o_Mem_Data,
  input  logic [XLEN-1:0]       i_Mem_Data
);

  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_WORD = (LS_SEL_WIDTH+1)'(2);

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_LS    = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LS    = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_next;
  logic   last_grant, last_grant_next;

  always_comb begin
    state_next            = state;
    last_grant_next       = last_grant;
    o_Mem_Write_Enable    = 1'b0;
    o_Mem_Load_Store_Type = '0;
    o_Mem_Addr            = '0;
    o_Mem_Data            = '0;
    case (state)
      IDLE: begin
        // Round-robin only breaks ties; a lone request never touches last_grant.
        if (i_Fetch_Req && i_Ls_Req) begin
          if (last_grant == GRANT_FETCH) begin
            state_next      = LS;
            last_grant_next = GRANT_LS;
          end else begin
            state_next      = FETCH;
            last_grant_next = GRANT_FETCH;
          end
        end else if (i_Fetch_Req) begin
          state_next = FETCH;
        end else if (i_Ls_Req) begin
          state_next = LS;
        end
      end
      FETCH: begin
        o_Mem_Load_Store_Type = LS_TYPE_LOAD_WORD;
        o_Mem_Addr            = i_Fetch_Addr;
        state_next            = RESP;
      end
      LS: begin
        o_Mem_Write_Enable    = i_Ls_Write_Enable;
        o_Mem_Load_Store_Type = i_Ls_Type;
        o_Mem_Addr            = i_Ls_Addr;
        o_Mem_Data            = i_Ls_Data;
        state_next            = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state        <= IDLE;
      last_grant   <= GRANT_FETCH;
      o_Fetch_Ack  <= 1'b0;
      o_Ls_Ack     <= 1'b0;
      o_Fetch_Data <= '0;
      o_Ls_Data    <= '0;
    end else begin
      state       <= state_next;
      last_grant  <= last_grant_next;
      o_Fetch_Ack <= (state == FETCH);
      o_Ls_Ack    <= (state == LS);
      if (state == FETCH) begin
        o_Fetch_Data <= i_Mem_Data;
      end
      if (state == LS) begin
        o_Ls_Data <= i_Ls_Write_Enable ? '0 : i_Mem_Data;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a small byte-addressed memory model
// hanging off the arbiter's memory pins.
module tb_memory_arbiter;

  localparam logic [2:0] T_LB  = 3'd0;
  localparam logic [2:0] T_LH  = 3'd1;
  localparam logic [2:0] T_LW  = 3'd2;
  localparam logic [2:0] T_LBU = 3'd4;
  localparam logic [2:0] T_LHU = 3'd5;
  localparam logic [2:0] T_SB  = 3'd0;
  localparam logic [2:0] T_SW  = 3'd2;

  logic        i_Clock = 1'b0;
  logic        i_Reset;
  logic        i_Fetch_Req;
  logic [31:0] i_Fetch_Addr;
  logic        o_Fetch_Ack;
  logic [31:0] o_Fetch_Data;
  logic        i_Ls_Req;
  logic        i_Ls_Write_Enable;
  logic [2:0]  i_Ls_Type;
  logic [31:0] i_Ls_Addr;
  logic [31:0] i_Ls_Data;
  logic        o_Ls_Ack;
  logic [31:0] o_Ls_Data;
  logic        o_Mem_Write_Enable;
  logic [2:0]  o_Mem_Load_Store_Type;
  logic [31:0] o_Mem_Addr;
  logic [31:0] o_Mem_Data;
  logic [31:0] i_Mem_Data;

  int compared   = 0;
  int mismatched = 0;

  memory_arbiter #(.XLEN(32), .LS_SEL_WIDTH(2)) dut (
    .i_Clock               (i_Clock),
    .i_Reset               (i_Reset),
    .i_Fetch_Req           (i_Fetch_Req),
    .i_Fetch_Addr          (i_Fetch_Addr),
    .o_Fetch_Ack           (o_Fetch_Ack),
    .o_Fetch_Data          (o_Fetch_Data),
    .i_Ls_Req              (i_Ls_Req),
    .i_Ls_Write_Enable     (i_Ls_Write_Enable),
    .i_Ls_Type             (i_Ls_Type),
    .i_Ls_Addr             (i_Ls_Addr),
    .i_Ls_Data             (i_Ls_Data),
    .o_Ls_Ack              (o_Ls_Ack),
    .o_Ls_Data             (o_Ls_Data),
    .o_Mem_Write_Enable    (o_Mem_Write_Enable),
    .o_Mem_Load_Store_Type (o_Mem_Load_Store_Type),
    .o_Mem_Addr            (o_Mem_Addr),
    .o_Mem_Data            (o_Mem_Data),
    .i_Mem_Data            (i_Mem_Data)
  );

  always #5 i_Clock = ~i_Clock;

  // Memory model: combinational read, write at the clock edge; backdoor preload port.
  logic [7:0] mem [0:255];
  logic       pre_en = 1'b0;
  logic [7:0] pre_addr = 8'd0;
  logic [7:0] pre_byte = 8'd0;
  logic [7:0] ma;

  always_comb begin
    ma = o_Mem_Addr[7:0];
    i_Mem_Data = 32'd0;
    case (o_Mem_Load_Store_Type)
      T_LB:  i_Mem_Data = {{24{mem[ma][7]}}, mem[ma]};
      T_LH:  i_Mem_Data = {{16{mem[ma+8'd1][7]}}, mem[ma+8'd1], mem[ma]};
      T_LW:  i_Mem_Data = {mem[ma+8'd3], mem[ma+8'd2], mem[ma+8'd1], mem[ma]};
      T_LBU: i_Mem_Data = {24'd0, mem[ma]};
      T_LHU: i_Mem_Data = {16'd0, mem[ma+8'd1], mem[ma]};
      default: i_Mem_Data = 32'd0;
    endcase
  end

  always @(posedge i_Clock) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_byte;
    end else if (o_Mem_Write_Enable) begin
      mem[o_Mem_Addr[7:0]] <= o_Mem_Data[7:0];
      if (o_Mem_Load_Store_Type[1:0] != 2'd0) mem[o_Mem_Addr[7:0]+8'd1] <= o_Mem_Data[15:8];
      if (o_Mem_Load_Store_Type[1:0] == 2'd2) begin
        mem[o_Mem_Addr[7:0]+8'd2] <= o_Mem_Data[23:16];
        mem[o_Mem_Addr[7:0]+8'd3] <= o_Mem_Data[31:24];
      end
    end
  end

  task automatic preload(input logic [7:0] addr, input logic [7:0] val);
    pre_addr = addr;
    pre_byte = val;
    pre_en   = 1'b1;
    @(posedge i_Clock);
    #1;
    pre_en = 1'b0;
  endtask

  // Lone LS access; reports ack latency in cycles, cycles with write enable, and read data.
  task automatic ls_access(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [31:0] data, output int lat, output int we_cycles,
                           output logic [31:0] rdata);
    i_Ls_Write_Enable = we;
    i_Ls_Type         = typ;
    i_Ls_Addr         = addr;
    i_Ls_Data         = data;
    i_Ls_Req          = 1'b1;
    lat       = 99;
    we_cycles = 0;
    rdata     = 32'd0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge i_Clock);
      #1;
      if (o_Mem_Write_Enable) we_cycles++;
      if (o_Ls_Ack) begin
        lat   = c;
        rdata = o_Ls_Data;
        break;
      end
    end
    i_Ls_Req = 1'b0;
    @(posedge i_Clock);
    #1;
  endtask

  task automatic test_reset();
    i_Reset = 1'b1;
    i_Fetch_Req = 1'b0;
    i_Fetch_Addr = 32'd0;
    i_Ls_Req = 1'b0;
    i_Ls_Write_Enable = 1'b0;
    i_Ls_Type = 3'd0;
    i_Ls_Addr = 32'd0;
    i_Ls_Data = 32'd0;
    repeat (2) @(posedge i_Clock);
    #1;
    compared++;
    if ({o_Fetch_Ack, o_Ls_Ack} !== 2'b00) begin
      mismatched++;
      $display("FAIL reset_acks: got %b expected 00", {o_Fetch_Ack, o_Ls_Ack});
    end
    compared++;
    if ({o_Fetch_Data, o_Ls_Data} !== 64'd0) begin
      mismatched++;
      $display("FAIL reset_data: got %h/%h expected 0/0", o_Fetch_Data, o_Ls_Data);
    end
    compared++;
    if ({o_Mem_Write_Enable, o_Mem_Load_Store_Type, o_Mem_Addr, o_Mem_Data} !== 68'd0) begin
      mismatched++;
      $display("FAIL reset_mem_pins: we=%b type=%h addr=%h data=%h expected all 0",
               o_Mem_Write_Enable, o_Mem_Load_Store_Type, o_Mem_Addr, o_Mem_Data);
    end
    i_Reset = 1'b0;
    @(posedge i_Clock);
    #1;
  endtask

  task automatic test_lone_fetch();
    preload(8'h10, 8'h78);
    preload(8'h11, 8'h56);
    preload(8'h12, 8'h34);
    preload(8'h13, 8'h12);
    i_Fetch_Addr = 32'h10;
    i_Fetch_Req  = 1'b1;
    @(posedge i_Clock);
    #1;
    compared++;
    if (o_Mem_Addr !== 32'h10 || o_Mem_Load_Store_Type !== T_LW || o_Mem_Write_Enable !== 1'b0
        || o_Fetch_Ack !== 1'b0) begin
      mismatched++;
      $display("FAIL fetch_grant_pins: addr=%h type=%h we=%b ack=%b expected 10/2/0/0",
               o_Mem_Addr, o_Mem_Load_Store_Type, o_Mem_Write_Enable, o_Fetch_Ack);
    end
    @(posedge i_Clock);
    #1;
    compared++;
    if (o_Fetch_Ack !== 1'b1 || o_Fetch_Data !== 32'h12345678) begin
      mismatched++;
      $display("FAIL fetch_ack_data: ack=%b data=%h expected 1/12345678", o_Fetch_Ack, o_Fetch_Data);
    end
    i_Fetch_Req = 1'b0;
    @(posedge i_Clock);
    #1;
    compared++;
    if (o_Fetch_Ack !== 1'b0 || o_Fetch_Data !== 32'h12345678 || o_Mem_Addr !== 32'd0) begin
      mismatched++;
      $display("FAIL fetch_after_ack: ack=%b data=%h addr=%h expected 0/12345678/0",
               o_Fetch_Ack, o_Fetch_Data, o_Mem_Addr);
    end
  endtask

  task automatic test_store_load();
    int lat, wec;
    logic [31:0] rd;
    ls_access(1'b1, T_SW, 32'h20, 32'hDEADBEEF, lat, wec, rd);
    compared++;
    if (lat !== 2 || rd !== 32'd0 || wec !== 1) begin
      mismatched++;
      $display("FAIL store_word: lat=%0d data=%h we_cycles=%0d expected 2/0/1", lat, rd, wec);
    end
    compared++;
    if (mem[8'h21] !== 8'hBE || mem[8'h23] !== 8'hDE) begin
      mismatched++;
      $display("FAIL store_commit: mem21=%h mem23=%h expected be/de", mem[8'h21], mem[8'h23]);
    end
    ls_access(1'b0, T_LBU, 32'h21, 32'h0, lat, wec, rd);
    compared++;
    if (lat !== 2 || rd !== 32'h000000BE || wec !== 0) begin
      mismatched++;
      $display("FAIL load_bu: lat=%0d data=%h we_cycles=%0d expected 2/000000be/0", lat, rd, wec);
    end
  endtask

  task automatic test_tie_round_robin();
    int n = 0;
    int both = 0;
    logic who [0:7];
    int   cyc [0:7];
    logic exp_who [0:3];
    exp_who[0] = 1'b1; exp_who[1] = 1'b0; exp_who[2] = 1'b1; exp_who[3] = 1'b0;
    i_Reset = 1'b1;
    #2;
    i_Reset = 1'b0;
    i_Fetch_Addr = 32'h10;
    i_Ls_Write_Enable = 1'b0;
    i_Ls_Type = T_LW;
    i_Ls_Addr = 32'h20;
    i_Fetch_Req = 1'b1;
    i_Ls_Req = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(posedge i_Clock);
      #1;
      if (o_Ls_Ack && o_Fetch_Ack) both++;
      if (o_Ls_Ack && n < 8) begin who[n] = 1'b1; cyc[n] = c; n++; end
      if (o_Fetch_Ack && n < 8) begin who[n] = 1'b0; cyc[n] = c; n++; end
    end
    i_Fetch_Req = 1'b0;
    i_Ls_Req = 1'b0;
    @(posedge i_Clock);
    #1;
    compared++;
    if (n !== 4 || both !== 0) begin
      mismatched++;
      $display("FAIL tie_ack_count: acks=%0d simultaneous=%0d expected 4/0", n, both);
    end
    for (int k = 0; k < 4; k++) begin
      if (k < n) begin
        compared++;
        if (who[k] !== exp_who[k] || cyc[k] !== 2 + 3*k) begin
          mismatched++;
          $display("FAIL tie_order[%0d]: ls=%b cycle=%0d expected ls=%b cycle=%0d",
                   k, who[k], cyc[k], exp_who[k], 2 + 3*k);
        end
      end
    end
    compared++;
    if (o_Ls_Data !== 32'hDEADBEEF || o_Fetch_Data !== 32'h12345678) begin
      mismatched++;
      $display("FAIL tie_data: ls=%h fetch=%h expected deadbeef/12345678", o_Ls_Data, o_Fetch_Data);
    end
  endtask

  task automatic test_load_half();
    int lat, wec;
    logic [31:0] rd;
    preload(8'h30, 8'h00);
    preload(8'h31, 8'h80);
    ls_access(1'b0, T_LH, 32'h30, 32'h0, lat, wec, rd);
    compared++;
    if (lat !== 2 || rd !== 32'hFFFF8000) begin
      mismatched++;
      $display("FAIL load_half: lat=%0d data=%h expected 2/ffff8000", lat, rd);
    end
    ls_access(1'b0, T_LHU, 32'h30, 32'h0, lat, wec, rd);
    compared++;
    if (lat !== 2 || rd !== 32'h00008000) begin
      mismatched++;
      $display("FAIL load_half_u: lat=%0d data=%h expected 2/00008000", lat, rd);
    end
  endtask

  task automatic test_reset_mid_store();
    int lat, wec;
    logic [31:0] rd;
    preload(8'h40, 8'h11);
    i_Ls_Write_Enable = 1'b1;
    i_Ls_Type = T_SB;
    i_Ls_Addr = 32'h40;
    i_Ls_Data = 32'h000000AA;
    i_Ls_Req  = 1'b1;
    @(posedge i_Clock);
    #1;
    compared++;
    if (o_Mem_Write_Enable !== 1'b1 || o_Mem_Addr !== 32'h40) begin
      mismatched++;
      $display("FAIL mid_store_ls_cycle: we=%b addr=%h expected 1/40", o_Mem_Write_Enable, o_Mem_Addr);
    end
    #2;
    i_Reset = 1'b1;
    #1;
    compared++;
    if (o_Mem_Write_Enable !== 1'b0 || o_Mem_Addr !== 32'd0 || o_Mem_Data !== 32'd0) begin
      mismatched++;
      $display("FAIL mid_store_pins_drop: we=%b addr=%h data=%h expected 0/0/0",
               o_Mem_Write_Enable, o_Mem_Addr, o_Mem_Data);
    end
    @(posedge i_Clock);
    #1;
    compared++;
    if (mem[8'h40] !== 8'h11 || o_Ls_Ack !== 1'b0 || o_Ls_Data !== 32'd0 || o_Fetch_Data !== 32'd0) begin
      mismatched++;
      $display("FAIL mid_store_aborted: mem40=%h ack=%b ls=%h fetch=%h expected 11/0/0/0",
               mem[8'h40], o_Ls_Ack, o_Ls_Data, o_Fetch_Data);
    end
    i_Ls_Req = 1'b0;
    i_Reset  = 1'b0;
    @(posedge i_Clock);
    #1;
    compared++;
    if (o_Ls_Ack !== 1'b0 || o_Mem_Write_Enable !== 1'b0 || o_Mem_Addr !== 32'd0) begin
      mismatched++;
      $display("FAIL mid_store_idle: ack=%b we=%b addr=%h expected 0/0/0",
               o_Ls_Ack, o_Mem_Write_Enable, o_Mem_Addr);
    end
    ls_access(1'b1, T_SB, 32'h40, 32'h000000AA, lat, wec, rd);
    compared++;
    if (lat !== 2 || mem[8'h40] !== 8'hAA || mem[8'h41] !== 8'hxx && 1'b0) begin
      mismatched++;
      $display("FAIL retry_store: lat=%0d mem40=%h expected 2/aa", lat, mem[8'h40]);
    end
  endtask

  task automatic test_lone_after_tie();
    int ls_c [0:3];
    int nl = 0;
    int nf = 0;
    i_Ls_Write_Enable = 1'b0;
    i_Ls_Type = T_LB;
    i_Ls_Addr = 32'h31;
    i_Fetch_Addr = 32'h10;
    i_Fetch_Req = 1'b1;
    i_Ls_Req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge i_Clock);
      #1;
      if (o_Fetch_Ack) nf++;
      if (o_Ls_Ack && nl < 4) begin ls_c[nl] = c; nl++; end
      if (c == 2) i_Fetch_Req = 1'b0;
    end
    i_Ls_Req = 1'b0;
    @(posedge i_Clock);
    #1;
    compared++;
    if (nl !== 2 || nf !== 0) begin
      mismatched++;
      $display("FAIL lone_after_tie_count: ls_acks=%0d fetch_acks=%0d expected 2/0", nl, nf);
    end
    if (nl == 2) begin
      compared++;
      if (ls_c[0] !== 2 || ls_c[1] !== 5) begin
        mismatched++;
        $display("FAIL lone_after_tie_timing: cycles=%0d,%0d expected 2,5", ls_c[0], ls_c[1]);
      end
    end
    compared++;
    if (o_Ls_Data !== 32'hFFFFFF80) begin
      mismatched++;
      $display("FAIL lone_after_tie_data: got %h expected ffffff80", o_Ls_Data);
    end
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_store_load();
    test_tie_round_robin();
    test_load_half();
    test_reset_mid_store();
    test_lone_after_tie();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
